// File: rtl/upsampler_pkg.sv
// Shared constants for the I/Q upsampler: per-symbol mode encodings and default sizes.
package upsampler_pkg;
  localparam logic MODE_ZERO = 1'b0;
  localparam logic MODE_HOLD = 1'b1;
  localparam int   UPS_W_DEF = 4;
  localparam int   UPS_L_DEF = 11;
endpackage

// File: rtl/ups_sym_buf.sv
// One-entry {mode, I, Q} buffer: loads on in_valid && in_ready, empties on fetch.
// in_ready is the only combinational path (gated low during reset).
module ups_sym_buf import upsampler_pkg::*; #(
  parameter int W = UPS_W_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic signed [W-1:0] in_i,
  input  logic signed [W-1:0] in_q,
  input  logic                in_mode,
  input  logic                fetch,
  output logic                full,
  output logic signed [W-1:0] buf_i,
  output logic signed [W-1:0] buf_q,
  output logic                buf_mode
);
  logic                r_full;
  logic signed [W-1:0] r_i;
  logic signed [W-1:0] r_q;
  logic                r_mode;
  logic                w_load;

  assign in_ready = !r_full && !reset;
  assign w_load   = in_valid && in_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_full <= 1'b0;
      r_i    <= '0;
      r_q    <= '0;
      r_mode <= MODE_ZERO;
    end else if (w_load) begin
      r_full <= 1'b1;
      r_i    <= in_i;
      r_q    <= in_q;
      r_mode <= in_mode;
    end else if (fetch) begin
      r_full <= 1'b0;
    end
  end

  assign full     = r_full;
  assign buf_i    = r_i;
  assign buf_q    = r_q;
  assign buf_mode = r_mode;
endmodule

// File: rtl/iq_upsampler.sv
// I/Q upsampler by L: phase 0 carries the symbol, phases 1..L-1 carry zeros or repeats.
// Two-cycle latency from idle; all outputs registered except in_ready.
module iq_upsampler import upsampler_pkg::*; #(
  parameter int W  = UPS_W_DEF,
  parameter int L  = UPS_L_DEF,
  parameter int PW = $clog2(L)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic signed [W-1:0] in_i,
  input  logic signed [W-1:0] in_q,
  input  logic                in_mode,
  output logic                out_valid,
  input  logic                out_ready,
  output logic signed [W-1:0] out_i,
  output logic signed [W-1:0] out_q,
  output logic [PW-1:0]       out_phase,
  output logic                underrun,
  input  logic                underrun_clr
);
  generate
    if (L < 2 || L > 16) begin : g_bad_l
      $error("iq_upsampler: L must be in 2..16");
    end
  endgenerate

  logic                w_full;
  logic                w_buf_mode;
  logic signed [W-1:0] w_buf_i;
  logic signed [W-1:0] w_buf_q;
  logic                w_adv;
  logic                w_last;
  logic                w_step;
  logic                w_fetch;
  logic                w_ur_set;

  logic                r_out_valid;
  logic signed [W-1:0] r_out_i;
  logic signed [W-1:0] r_out_q;
  logic [PW-1:0]       r_phase;
  logic signed [W-1:0] r_sym_i;
  logic signed [W-1:0] r_sym_q;
  logic                r_mode;
  logic                r_underrun;

  ups_sym_buf #(.W(W)) u_buf (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_i     (in_i),
    .in_q     (in_q),
    .in_mode  (in_mode),
    .fetch    (w_fetch),
    .full     (w_full),
    .buf_i    (w_buf_i),
    .buf_q    (w_buf_q),
    .buf_mode (w_buf_mode)
  );

  assign w_adv    = !r_out_valid || out_ready;
  assign w_last   = (r_phase == PW'(L - 1));
  assign w_step   = w_adv && r_out_valid && !w_last;
  assign w_fetch  = w_adv && !w_step && w_full;
  // Stream broke: the final phase leaves with nothing queued behind it.
  assign w_ur_set = r_out_valid && out_ready && w_last && !w_full;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_out_valid <= 1'b0;
      r_out_i     <= '0;
      r_out_q     <= '0;
      r_phase     <= '0;
      r_sym_i     <= '0;
      r_sym_q     <= '0;
      r_mode      <= MODE_ZERO;
    end else if (w_step) begin
      r_phase <= r_phase + PW'(1);
      r_out_i <= (r_mode == MODE_HOLD) ? r_sym_i : '0;
      r_out_q <= (r_mode == MODE_HOLD) ? r_sym_q : '0;
    end else if (w_fetch) begin
      r_out_valid <= 1'b1;
      r_phase     <= '0;
      r_out_i     <= w_buf_i;
      r_out_q     <= w_buf_q;
      r_sym_i     <= w_buf_i;
      r_sym_q     <= w_buf_q;
      r_mode      <= w_buf_mode;
    end else if (w_adv) begin
      r_out_valid <= 1'b0;
      r_phase     <= '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_underrun <= 1'b0;
    end else if (w_ur_set) begin
      r_underrun <= 1'b1;
    end else if (underrun_clr) begin
      r_underrun <= 1'b0;
    end
  end

  assign out_valid = r_out_valid;
  assign out_i     = r_out_i;
  assign out_q     = r_out_q;
  assign out_phase = r_phase;
  assign underrun  = r_underrun;
endmodule

// File: tb/tb_iq_upsampler.sv
// Directed bench for iq_upsampler (W=4, L=11): zero/hold modes, streaming, stalls, reset, underrun.
module tb_iq_upsampler;
  localparam int W  = 4;
  localparam int L  = 11;
  localparam int PW = $clog2(L);
  localparam int SW = PW + 2 * W;

  logic                clk = 1'b0;
  logic                reset;
  logic                in_valid;
  logic                in_ready;
  logic signed [W-1:0] in_i;
  logic signed [W-1:0] in_q;
  logic                in_mode;
  logic                out_valid;
  logic                out_ready;
  logic signed [W-1:0] out_i;
  logic signed [W-1:0] out_q;
  logic [PW-1:0]       out_phase;
  logic                underrun;
  logic                underrun_clr;

  always #5 clk = ~clk;

  iq_upsampler #(.W(W), .L(L)) dut (
    .clk          (clk),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_i         (in_i),
    .in_q         (in_q),
    .in_mode      (in_mode),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_i        (out_i),
    .out_q        (out_q),
    .out_phase    (out_phase),
    .underrun     (underrun),
    .underrun_clr (underrun_clr)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  typedef struct packed {
    logic                mode;
    logic signed [W-1:0] i;
    logic signed [W-1:0] q;
  } sym_t;

  sym_t          syms[$];
  logic [SW-1:0] expq[$];
  logic [SW-1:0] gotq[$];

  function automatic sym_t mk(input int i, input int q, input logic m);
    sym_t s;
    s.mode = m;
    s.i    = W'(i);
    s.q    = W'(q);
    return s;
  endfunction

  function automatic void build_exp();
    logic [PW-1:0]       ph;
    logic signed [W-1:0] zero;
    zero = '0;
    expq.delete();
    foreach (syms[s]) begin
      for (int p = 0; p < L; p++) begin
        ph = PW'(p);
        if (p == 0 || syms[s].mode)
          expq.push_back({ph, syms[s].i, syms[s].q});
        else
          expq.push_back({ph, zero, zero});
      end
    end
  endfunction

  task automatic clear_ur();
    @(negedge clk);
    underrun_clr = 1'b1;
    @(negedge clk);
    underrun_clr = 1'b0;
    check("ur_clear", underrun, 1'b0);
  endtask

  // Feeds syms[] and collects every consumed sample; all decisions made on the falling edge.
  task automatic run_stream(input string name, input bit stall, input bit wiggle, input bit clr_last,
                            output int first_cyc, output int last_cyc, output int ir_cnt);
    int            idx;
    int            cyc;
    bit            stalled;
    bit            saw_ur;
    logic [SW-1:0] held;
    idx = 0; cyc = 0; stalled = 0; saw_ur = 0; held = '0;
    first_cyc = -1; last_cyc = -1; ir_cnt = 0;
    build_exp();
    gotq.delete();
    while (gotq.size() < expq.size() && cyc < 2000) begin
      @(negedge clk);
      cyc++;
      if (stalled) check({name, "_stall_hold"}, {out_valid, out_phase, out_i, out_q}, {1'b1, held});
      out_ready    = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
      underrun_clr = clr_last && out_valid && (out_phase == PW'(L - 1));
      if (idx < syms.size()) begin
        in_valid = 1'b1;
        in_i     = syms[idx].i;
        in_q     = syms[idx].q;
        in_mode  = syms[idx].mode;
        if (wiggle && !in_ready) begin
          in_mode = 1'($urandom);
          in_i    = W'($urandom);
          in_q    = W'($urandom);
        end
      end else begin
        in_valid = 1'b0;
      end
      if (underrun) saw_ur = 1;
      if (in_ready) ir_cnt++;
      if (out_valid && out_ready) begin
        if (first_cyc < 0) first_cyc = cyc;
        last_cyc = cyc;
        gotq.push_back({out_phase, out_i, out_q});
      end
      stalled = out_valid && !out_ready;
      held    = {out_phase, out_i, out_q};
      if (in_valid && in_ready) idx++;
    end
    @(negedge clk);
    in_valid     = 1'b0;
    out_ready    = 1'b1;
    underrun_clr = 1'b0;
    check({name, "_len"}, gotq.size(), expq.size());
    for (int k = 0; k < expq.size() && k < gotq.size(); k++)
      check($sformatf("%s_s%0d", name, k), gotq[k], expq[k]);
    check({name, "_no_early_ur"}, saw_ur, 1'b0);
    check({name, "_ur_end"}, underrun, 1'b1);
    check({name, "_idle_end"}, out_valid, 1'b0);
  endtask

  int fc, lc, irc, guard;

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_i = '0; in_q = '0; in_mode = 1'b0;
    out_ready = 1'b1; underrun_clr = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_valid", out_valid, 1'b0);
    check("rst_i", out_i, '0);
    check("rst_q", out_q, '0);
    check("rst_phase", out_phase, '0);
    check("rst_ur", underrun, 1'b0);
    check("rst_in_ready", in_ready, 1'b0);
    reset = 1'b0;
    #1 check("rel_in_ready", in_ready, 1'b1);

    syms.delete(); syms.push_back(mk(3, -5, 1'b0));
    run_stream("zero", 0, 0, 0, fc, lc, irc);
    check("zero_latency", fc, 3);
    check("zero_span", lc - fc + 1, L);

    clear_ur();
    syms.delete(); syms.push_back(mk(3, -5, 1'b1));
    run_stream("hold", 0, 0, 0, fc, lc, irc);

    // Refill happens the cycle after each fetch; then in_ready stays high once the last symbol is taken.
    clear_ur();
    syms.delete();
    syms.push_back(mk(7, -8, 1'b0)); syms.push_back(mk(-1, 2, 1'b0)); syms.push_back(mk(0, 7, 1'b0));
    run_stream("cont", 0, 0, 0, fc, lc, irc);
    check("cont_gapless", lc - fc + 1, 3 * L);
    check("cont_in_ready_cnt", irc, 14);

    clear_ur();
    run_stream("stall", 1, 0, 0, fc, lc, irc);

    clear_ur();
    syms.delete();
    syms.push_back(mk(5, -3, 1'b0)); syms.push_back(mk(-6, 1, 1'b1)); syms.push_back(mk(2, 2, 1'b0));
    run_stream("mode", 0, 1, 0, fc, lc, irc);

    // Reset at phase 5 of one symbol with the next already buffered.
    clear_ur();
    guard = 0;
    @(negedge clk);
    in_valid = 1'b1; in_i = 4'sd4; in_q = 4'sd4; in_mode = 1'b0;
    while (in_ready && guard < 50) begin @(negedge clk); guard++; end
    in_i = -4'sd2; in_q = -4'sd2; in_mode = 1'b1;
    while (!(out_valid && out_phase == PW'(5)) && guard < 50) begin @(negedge clk); guard++; end
    in_valid = 1'b0;
    check("mid_reached", guard < 50, 1'b1);
    check("mid_buf_full", in_ready, 1'b0);
    reset = 1'b1;
    #1;
    check("mid_rst_valid", out_valid, 1'b0);
    check("mid_rst_i", out_i, '0);
    check("mid_rst_q", out_q, '0);
    check("mid_rst_phase", out_phase, '0);
    check("mid_rst_in_ready", in_ready, 1'b0);
    @(negedge clk);
    check("mid_rst_in_ready2", in_ready, 1'b0);
    reset = 1'b0;
    #1 check("mid_rel_in_ready", in_ready, 1'b1);
    syms.delete(); syms.push_back(mk(1, -1, 1'b1));
    run_stream("post_rst", 0, 0, 0, fc, lc, irc);
    check("post_rst_latency", fc, 3);

    clear_ur();
    syms.delete(); syms.push_back(mk(-8, 6, 1'b0));
    run_stream("set_wins", 0, 0, 1, fc, lc, irc);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/iq_upsampler.md
# iq_upsampler

Parametrised I/Q zero-stuffing upsampler for the QAM transmit chain, between the symbol mapper and the pulse-shaping filter. Each accepted I/Q symbol expands into `L` output samples: the symbol on phase 0, then `L-1` zeros (zero-stuff mode) or repeats (hold mode). It adds valid/ready flow control on both sides, a one-entry input buffer and a sticky underrun flag. It replaces the fixed-width, externally counted upsampler.

## Interface
- `W`, 4: signed sample width of I and Q.
- `L`, 11: upsampling factor. Legal range 2..16; elaboration error outside it.
- `PW`, `$clog2(L)`: phase counter width. Derived; do not override.

- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  input symbol valid.
- `in_ready`  out  1  `!buf_full && !reset`.
- `in_i`, `in_q`  in  W  signed symbol I and Q.
- `in_mode`  in  1  0 = zero-stuff, 1 = hold. Captured with the symbol.
- `out_valid`  out  1  output sample valid.
- `out_ready`  in  1  downstream accepts the sample.
- `out_i`, `out_q`  out  W  signed output sample.
- `out_phase`  out  PW  phase of the current sample, 0..L-1.
- `underrun`  out  1  sticky: the stream broke between symbols.
- `underrun_clr`  in  1  synchronous clear of `underrun`.

## Operation
- Input buffer: one entry holding I, Q and mode. It loads on `in_valid && in_ready` and empties on a generator fetch. A load and a fetch in the same cycle cannot occur, because `in_ready` is low while the buffer is full.
- Generator advance condition: `adv = !out_valid || out_ready`. When `adv` is 0, all outputs hold stable.
- On `adv`:
  - If `out_valid && out_phase != L-1`: phase increments. `out_i`/`out_q` take 0 in zero-stuff mode, or the latched symbol in hold mode.
  - Otherwise, if the buffer is full: fetch the buffer, `out_phase` = 0, `out_i`/`out_q` = symbol, latch the mode, `out_valid` = 1.
  - Otherwise: `out_valid` = 0 and `out_phase` = 0. If the phase-(L-1) sample is being consumed (`out_valid && out_ready`), set `underrun`.
- Mode is fixed for all L phases of a symbol. A change on `in_mode` affects only later symbols.
- `underrun_clr` clears the flag. If set and clear happen in the same cycle, set wins.
- No arithmetic is performed; samples pass through bit-exact as signed W-bit values.
- Reset: `out_valid` = 0, `out_i` = `out_q` = 0, `out_phase` = 0, `underrun` = 0, buffer empty. `in_ready` is 0 while `reset` is high and 1 on the first cycle after release.
- Reset mid-symbol discards the buffered symbol and the partial symbol with no trailing zeros. The first symbol after release restarts at phase 0.

## Timing
- From idle: a symbol accepted at edge k sets `buf_full` after k. Phase 0 is on the outputs after edge k+1, so latency is 2 cycles.
- Back-to-back operation: the buffer empties at the phase-0 fetch and `in_ready` rises the next cycle. The upstream has L-1 cycles to refill it, so a continuous stream has no gaps.
- Throughput with `out_ready` = 1: one output sample per cycle and one input symbol per L cycles.
- The last phase is followed by the next symbol's phase 0 on the following edge when the buffer is full.
- `underrun` is visible the cycle after the phase-(L-1) sample is consumed with the buffer empty.
- `in_ready` is the only output with a combinational term (the reset gate). All other outputs come straight from flops.

## Structure
- `upsampler_pkg`: `MODE_ZERO` = 1'b0, `MODE_HOLD` = 1'b1, and default constants `UPS_W_DEF` = 4 and `UPS_L_DEF` = 11.
- One natural sub-module, `ups_sym_buf`: a one-entry valid/ready buffer for {mode, I, Q} with a fetch strobe.
- The top level holds the phase counter, the output registers and the underrun logic.

## Test plan
- Reset, then one symbol I=3, Q=-5 in zero-stuff mode with `out_ready` = 1. Expect phase 0 = (3,-5), then 10 samples of (0,0) with phases 1..10, then `out_valid` = 0 and `underrun` = 1.
- Same symbol in hold mode. Expect 11 samples all (3,-5), phases 0..10.
- Continuous stream (7,-8), (-1,2), (0,7) with `in_valid` always 1. Expect 33 contiguous valid samples with no gaps, `in_ready` pulsing once per 11 cycles, and `underrun` = 0 until after the last symbol.
- Random `out_ready` stalls. Expect outputs unchanged while stalled, no phase skipped or repeated, and the sample sequence identical to the unstalled run.
- Mode toggled between symbols 1 and 2, and `in_mode` wiggled mid-symbol. Expect the mode to switch only at the next phase 0.
- Reset asserted at phase 5 with a symbol buffered. Expect all outputs zero immediately, `in_ready` = 0 during reset, and the next symbol starting at phase 0. Also: `underrun_clr` in the same cycle as a new underrun leaves the flag set.
